// File: rtl/pipe_hazard_ctl.sv
// Hazard and pipeline-control unit for the five-stage pipeline.
// Shadows EX/MEM/WB control state to drive stalls, flushes and forwarding.
module pipe_hazard_ctl #(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_LAT    = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_memwrite,
    input  logic                  mem_branch_taken,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  mem_wb_flush,
    output logic [1:0]            ex_fwd_a,
    output logic [1:0]            ex_fwd_b,
    output logic                  id_byp_a,
    output logic                  id_byp_b,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    typedef enum logic [2:0] {
        ACT_RUN,
        ACT_RESET,
        ACT_BUSY,
        ACT_BRANCH,
        ACT_STALL
    } act_t;

    localparam logic [2:0] MEM_LOAD = 3'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // EX shadow
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  ex_uses_rs;
    logic                  ex_uses_rt;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_regwrite;
    logic                  ex_memread;
    logic                  ex_memwrite;

    // MEM shadow
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  mem_regwrite;
    logic                  mem_memread;

    // WB shadow
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic                  wb_regwrite;

    logic [2:0] mem_cnt;
    logic       mem_busy;
    logic       load_use;
    act_t       act;

    logic ex_load;
    logic ex_clear;
    logic mem_load;
    logic mem_clear;
    logic wb_load;
    logic wb_clear;
    logic ex_is_mem;

    // A stage producing register r; r0 never matches
    function automatic logic hit(
        input logic                  v,
        input logic                  rw,
        input logic [REG_ADDR_W-1:0] d,
        input logic [REG_ADDR_W-1:0] r
    );
        return v & rw & (d == r) & (r != '0);
    endfunction

    assign mem_busy  = (mem_cnt != 3'd0);
    assign ex_is_mem = ex_valid & (ex_memread | ex_memwrite);

    // Consumer in ID needs the load currently in EX
    always_comb begin
        load_use = 1'b0;
        if (id_valid && ex_valid && ex_memread && ex_dest != '0) begin
            load_use = (id_uses_rs && ex_dest == id_rs) ||
                       (id_uses_rt && ex_dest == id_rt);
        end
    end

    // Select the pipeline action by priority
    always_comb begin
        act = ACT_RUN;
        if (rst) begin
            act = ACT_RESET;
        end else if (mem_busy) begin
            act = ACT_BUSY;
        end else if (mem_branch_taken) begin
            act = ACT_BRANCH;
        end else if (load_use) begin
            act = ACT_STALL;
        end
    end

    // Enables, flushes and shadow-register load/clear strobes per action
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        ex_load      = 1'b0;
        ex_clear     = 1'b0;
        mem_load     = 1'b0;
        mem_clear    = 1'b0;
        wb_load      = 1'b0;
        wb_clear     = 1'b0;
        unique case (act)
            ACT_RESET: begin
                ex_clear  = 1'b1;
                mem_clear = 1'b1;
                wb_clear  = 1'b1;
            end
            ACT_BUSY: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_en    = 1'b0;
                mem_wb_flush = 1'b1;
                wb_clear     = 1'b1;
            end
            ACT_BRANCH: begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                ex_clear     = 1'b1;
                mem_clear    = 1'b1;
                wb_load      = 1'b1;
            end
            ACT_STALL: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
                ex_clear    = 1'b1;
                mem_load    = 1'b1;
                wb_load     = 1'b1;
            end
            default: begin
                ex_load  = 1'b1;
                mem_load = 1'b1;
                wb_load  = 1'b1;
            end
        endcase
    end

    // EX shadow: capture ID or take a bubble
    always_ff @(posedge clk) begin
        if (ex_clear) begin
            ex_valid <= 1'b0;
        end else if (ex_load) begin
            ex_valid    <= id_valid;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_uses_rs  <= id_uses_rs;
            ex_uses_rt  <= id_uses_rt;
            ex_dest     <= id_dest;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_memwrite <= id_memwrite;
        end
    end

    // MEM shadow: capture EX or drop on branch/reset
    always_ff @(posedge clk) begin
        if (mem_clear) begin
            mem_valid <= 1'b0;
        end else if (mem_load) begin
            mem_valid    <= ex_valid;
            mem_dest     <= ex_dest;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
        end
    end

    // WB shadow: capture MEM or take a bubble during a freeze
    always_ff @(posedge clk) begin
        if (wb_clear) begin
            wb_valid <= 1'b0;
        end else if (wb_load) begin
            wb_valid    <= mem_valid;
            wb_dest     <= mem_dest;
            wb_regwrite <= mem_regwrite;
        end
    end

    // Remaining freeze cycles of the access sitting in MEM
    always_ff @(posedge clk) begin
        if (act == ACT_RESET) begin
            mem_cnt <= 3'd0;
        end else if (act == ACT_BUSY) begin
            mem_cnt <= mem_cnt - 3'd1;
        end else if (mem_load && ex_is_mem) begin
            mem_cnt <= MEM_LOAD;
        end
    end

    // Saturating stall and flush event counters
    always_ff @(posedge clk) begin
        if (act == ACT_RESET) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (act == ACT_STALL && stall_count != CNT_MAX) begin
                stall_count <= stall_count + 1'b1;
            end
            if (act == ACT_BRANCH && flush_count != CNT_MAX) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

    // EX operand forwarding, younger MEM result wins over WB
    always_comb begin
        ex_fwd_a = 2'b00;
        ex_fwd_b = 2'b00;
        if (ex_uses_rs && hit(mem_valid, mem_regwrite, mem_dest, ex_rs) && !mem_memread) begin
            ex_fwd_a = 2'b01;
        end else if (ex_uses_rs && hit(wb_valid, wb_regwrite, wb_dest, ex_rs)) begin
            ex_fwd_a = 2'b10;
        end
        if (ex_uses_rt && hit(mem_valid, mem_regwrite, mem_dest, ex_rt) && !mem_memread) begin
            ex_fwd_b = 2'b01;
        end else if (ex_uses_rt && hit(wb_valid, wb_regwrite, wb_dest, ex_rt)) begin
            ex_fwd_b = 2'b10;
        end
    end

    // ID register-file bypass from the instruction writing back this cycle
    always_comb begin
        id_byp_a = id_uses_rs & hit(wb_valid, wb_regwrite, wb_dest, id_rs);
        id_byp_b = id_uses_rt & hit(wb_valid, wb_regwrite, wb_dest, id_rt);
    end

endmodule
